dds_phase_accumulator: RTL and testbench

- Numerically controlled oscillator that generates the phase address for the waveform lookup ROMs in the DDS datapath (triangle, sine, etc.).
- Accumulates a frequency tuning word every enabled cycle and outputs the truncated phase plus a programmable offset as the ROM address.
- Accepts new tuning words over a valid/ready handshake, applied either immediately or phase-continuously at the next wrap.

---
 rtl/dds_phase_accumulator.sv | 134 +++++++++++++
 tb/tb_dds_phase_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_accumulator.sv
// Phase accumulator (NCO) producing waveform ROM addresses with a tuning-word handshake.
// Optional DDS_FREQ_SWEEP_EN adds a per-wrap linear frequency sweep between a base word and a limit.
module dds_phase_accumulator #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [ACC_W-1:0]   fword_in,
    input  logic               fword_valid,
    output logic               fword_ready,
    input  logic               update_mode,
    input  logic [PHASE_W-1:0] poffset,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap,
    output logic [ACC_W-1:0]   fword_cur
`ifdef DDS_FREQ_SWEEP_EN
    ,
    input  logic               sweep_en,
    input  logic [ACC_W-1:0]   sweep_step,
    input  logic [ACC_W-1:0]   sweep_limit
`endif
);

    typedef enum logic {
        S_READY = 1'b0,
        S_PEND  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] pend, pend_nx;
    logic [ACC_W-1:0] fword_nx;
    logic             ready_nx;
    logic             en_d;
    logic             carry_q;
    logic [ACC_W:0]   sum;
    logic             carry_now;
    logic             xfer;

`ifdef DDS_FREQ_SWEEP_EN
    logic [ACC_W-1:0] sweep_base, sweep_base_nx;
    logic [ACC_W:0]   sweep_sum;
`endif

    // Carry out of the widened add marks the accumulator wrapping past 2^ACC_W.
    assign sum       = {1'b0, acc} + {1'b0, fword_cur};
    assign carry_now = en & sum[ACC_W];
    assign xfer      = fword_valid & fword_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        fword_nx = fword_cur;
        pend_nx  = pend;
        ready_nx = 1'b0;
`ifdef DDS_FREQ_SWEEP_EN
        sweep_base_nx = sweep_base;
        sweep_sum     = {1'b0, fword_cur} + {1'b0, sweep_step};
`endif
        case (state)
            S_READY: begin
                ready_nx = 1'b1;
`ifdef DDS_FREQ_SWEEP_EN
                if (carry_now && sweep_en) begin
                    if (sweep_sum[ACC_W] || (sweep_sum[ACC_W-1:0] >= sweep_limit))
                        fword_nx = sweep_base;
                    else
                        fword_nx = sweep_sum[ACC_W-1:0];
                end
                if (xfer)
                    sweep_base_nx = fword_in;
`endif
                if (xfer) begin
                    if (update_mode) begin
                        pend_nx  = fword_in;
                        state_nx = S_PEND;
                        ready_nx = 1'b0;
                    end else begin
                        fword_nx = fword_in;
                    end
                end
            end
            S_PEND: begin
                // The wrap is judged with the old word; the pending word takes effect on the following add.
                if (carry_now) begin
                    fword_nx = pend;
                    state_nx = S_READY;
                    ready_nx = 1'b1;
                end
            end
            default: begin
                state_nx = S_READY;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            fword_cur   <= '0;
            pend        <= '0;
            state       <= S_READY;
            fword_ready <= 1'b0;
            en_d        <= 1'b0;
            carry_q     <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
            wrap        <= 1'b0;
`ifdef DDS_FREQ_SWEEP_EN
            sweep_base  <= '0;
`endif
        end else begin
            if (en)
                acc <= sum[ACC_W-1:0];
            carry_q     <= carry_now;
            en_d        <= en;
            phase       <= acc[ACC_W-1 -: PHASE_W] + poffset;
            phase_valid <= en_d;
            wrap        <= carry_q;
            state       <= state_nx;
            fword_cur   <= fword_nx;
            pend        <= pend_nx;
            fword_ready <= ready_nx;
`ifdef DDS_FREQ_SWEEP_EN
            sweep_base  <= sweep_base_nx;
`endif
        end
    end

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Scoreboard bench for dds_phase_accumulator: driver pushes expected samples, a negedge monitor pops them.
// The sweep section is compiled only when DDS_FREQ_SWEEP_EN is defined.
`timescale 1ns/1ps
module tb_dds_phase_accumulator;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 14;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [ACC_W-1:0]   fword_in;
    logic               fword_valid;
    logic               fword_ready;
    logic               update_mode;
    logic [PHASE_W-1:0] poffset;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               wrap;
    logic [ACC_W-1:0]   fword_cur;
`ifdef DDS_FREQ_SWEEP_EN
    logic               sweep_en;
    logic [ACC_W-1:0]   sweep_step;
    logic [ACC_W-1:0]   sweep_limit;
`endif

    dds_phase_accumulator #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fword_in    (fword_in),
        .fword_valid (fword_valid),
        .fword_ready (fword_ready),
        .update_mode (update_mode),
        .poffset     (poffset),
        .phase       (phase),
        .phase_valid (phase_valid),
        .wrap        (wrap),
        .fword_cur   (fword_cur)
`ifdef DDS_FREQ_SWEEP_EN
        ,
        .sweep_en    (sweep_en),
        .sweep_step  (sweep_step),
        .sweep_limit (sweep_limit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic               wrap;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   sb_on   = 1'b1;

    // Expected phase index (accumulator top bits) and tuning steps in units of one address per cycle.
    logic [PHASE_W-1:0] p;
    int                 cur_step;
    int                 pend_step;
    logic [PHASE_W-1:0] frozen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle; while enabled, the sample this add will produce two edges later is queued.
    task automatic tick();
        logic [PHASE_W:0] nxt;
        exp_t             e;
        if (en && sb_on) begin
            nxt     = {1'b0, p} + (PHASE_W+1)'(cur_step);
            e.phase = nxt[PHASE_W-1:0] + poffset;
            e.wrap  = nxt[PHASE_W];
            sb_q.push_back(e);
            p = nxt[PHASE_W-1:0];
            if (nxt[PHASE_W] && pend_step != 0) begin
                cur_step  = pend_step;
                pend_step = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [ACC_W-1:0] w, input logic mode, input int new_step);
        check("ready_before_send", 32'(fword_ready), 32'd1);
        fword_in    = w;
        update_mode = mode;
        fword_valid = 1'b1;
        tick();
        fword_valid = 1'b0;
        if (mode)
            pend_step = new_step;
        else
            cur_step = new_step;
    endtask

    always @(negedge clk) begin
        if (sb_on && !rst) begin
            if (phase_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got phase 0x%0h, expected no sample", phase);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sample_phase", 32'(phase), 32'(e.phase));
                    check("sample_wrap", 32'(wrap), 32'(e.wrap));
                end
            end else begin
                check("wrap_without_valid", 32'(wrap), 32'd0);
            end
        end
    end

`ifdef DDS_FREQ_SWEEP_EN
    task automatic wait_wrap_and_check(input logic [ACC_W-1:0] exp_word);
        int cnt = 0;
        while (!wrap && cnt < 20000) begin
            tick();
            cnt++;
        end
        check("sweep_wrap_seen", 32'(wrap), 32'd1);
        check("sweep_fword", fword_cur, exp_word);
        tick();
    endtask
`endif

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        fword_in    = '0;
        fword_valid = 1'b0;
        update_mode = 1'b0;
        poffset     = '0;
        p           = '0;
        cur_step    = 0;
        pend_step   = 0;
`ifdef DDS_FREQ_SWEEP_EN
        sweep_en    = 1'b0;
        sweep_step  = '0;
        sweep_limit = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_phase_valid", 32'(phase_valid), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_ready", 32'(fword_ready), 32'd0);
        check("rst_fword_cur", fword_cur, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_release", 32'(fword_ready), 32'd1);

        // One address per cycle: 0,1,...,16383 then 0 with wrap.
        en = 1'b1;
        send(32'h0004_0000, 1'b0, 1);
        repeat (16384) tick();
        check("fword_cur_step1", fword_cur, 32'h0004_0000);

        // Half-rate word: 0x2000 / 0x0000 with wrap on each 0x0000.
        en = 1'b0;
        repeat (2) tick();
        send(32'h8000_0000, 1'b0, 8192);
        en = 1'b1;
        repeat (4) tick();

        // Offset latency while idle, then offset 0x1000 with step 1.
        en = 1'b0;
        repeat (2) tick();
        poffset = 14'h0123;
        tick();
        check("poffset_latency", 32'(phase), 32'h0123);
        poffset = 14'h1000;
        send(32'h0004_0000, 1'b0, 1);
        en = 1'b1;
        repeat (100) tick();

        // Phase-continuous update: step stays 1 until the wrap, then 2.
        send(32'h0008_0000, 1'b1, 2);
        check("ready_low_in_pend", 32'(fword_ready), 32'd0);
        check("fword_old_in_pend", fword_cur, 32'h0004_0000);
        fword_in    = 32'h1234_0000;
        update_mode = 1'b0;
        fword_valid = 1'b1;
        repeat (5) begin
            tick();
            check("ready_held_low", 32'(fword_ready), 32'd0);
        end
        fword_valid = 1'b0;
        check("no_xfer_in_pend", fword_cur, 32'h0004_0000);
        repeat (16384 - 106) tick();
        check("pend_applied", fword_cur, 32'h0008_0000);
        check("ready_after_wrap", 32'(fword_ready), 32'd1);
        repeat (10) tick();

        // Enable low: phase frozen, no valid, no wrap.
        en = 1'b0;
        repeat (2) tick();
        frozen = p + poffset;
        repeat (8) begin
            tick();
            check("frozen_phase", 32'(phase), 32'(frozen));
            check("frozen_valid", 32'(phase_valid), 32'd0);
            check("frozen_wrap", 32'(wrap), 32'd0);
        end

        // Reset while a word is pending discards it.
        poffset = '0;
        send(32'h000C_0000, 1'b1, 3);
        check("pend_before_rst", 32'(fword_ready), 32'd0);
        rst = 1'b1;
        tick();
        pend_step = 0;
        cur_step  = 0;
        p         = '0;
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_valid", 32'(phase_valid), 32'd0);
        check("midrst_wrap", 32'(wrap), 32'd0);
        check("midrst_ready", 32'(fword_ready), 32'd0);
        check("midrst_fword_cur", fword_cur, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_midrst", 32'(fword_ready), 32'd1);
        en = 1'b1;
        repeat (4) tick();
        check("pend_discarded", fword_cur, 32'd0);
        en = 1'b0;
        repeat (3) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

`ifdef DDS_FREQ_SWEEP_EN
        sb_on       = 1'b0;
        sweep_step  = 32'h0004_0000;
        sweep_limit = 32'h0010_0000;
        sweep_en    = 1'b1;
        send(32'h0004_0000, 1'b0, 1);
        en = 1'b1;
        wait_wrap_and_check(32'h0008_0000);
        wait_wrap_and_check(32'h000C_0000);
        wait_wrap_and_check(32'h0004_0000);
        en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
